piso_shift_ctrl: RTL and testbench

//   Sequencer for the Lab 7 parallel-in/serial-out shift register.
//   - Owns the load/shift select that steers each per-bit 2:1 mux: 0 = load parallel input, 1 = shift neighbour.
//   - Holds the shift register and bit counter so that select and data stay in lockstep.
//   - Accepts a parallel word from an upstream producer through a valid/ready handshake.
//   - Emits the word one bit per enabled clock, then pulses done.
//

---
 rtl/piso_shift_ctrl.sv | 130 +++++++++++++
 tb/tb_piso_shift_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/piso_shift_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : piso_shift_ctrl
// Description : Sequencer for a parallel-in/serial-out shift register. Accepts
//               a parallel word over a valid/ready handshake, serialises it
//               one bit per enabled clock, then pulses done for one cycle.
//               Drives the per-bit load/shift mux select (0 = load, 1 = shift).
// Revision    : 1.0 - initial release
// ============================================================================
module piso_shift_ctrl #(
    parameter int WIDTH     = 4,     // parallel word width, 2 or more
    parameter bit LSB_FIRST = 1'b1,  // 1: bit 0 leaves first, 0: bit WIDTH-1 first
    parameter bit FILL      = 1'b0   // value entering the vacated end of the register
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] par_in,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             shift_en,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             sel_out,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // Count value held while the final bit of a frame is presented
    localparam logic [CW-1:0] c_last_bit = CW'(WIDTH - 1);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [WIDTH-1:0] r_sreg;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] w_shifted;
    logic             w_ser_bit;

    // Shift direction and output tap depend on serialisation order
    if (LSB_FIRST) begin : g_lsb_first
        assign w_shifted = {FILL, r_sreg[WIDTH-1:1]};
        assign w_ser_bit = r_sreg[0];
    end else begin : g_msb_first
        assign w_shifted = {r_sreg[WIDTH-2:0], FILL};
        assign w_ser_bit = r_sreg[WIDTH-1];
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Shift register and bit counter move in lockstep with the mux select
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sreg <= '0;
            r_cnt  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (load_valid) begin
                        r_sreg <= par_in;
                        r_cnt  <= '0;
                    end
                end
                ST_SHIFT: begin
                    if (shift_en) begin
                        r_sreg <= w_shifted;
                        r_cnt  <= r_cnt + CW'(1);
                    end
                end
                default: begin
                    r_sreg <= r_sreg;
                    r_cnt  <= r_cnt;
                end
            endcase
        end
    end

    // Next-state decode: frame ends once the last bit is shifted out
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (load_valid) w_state_nxt = ST_SHIFT;
            ST_SHIFT: if (shift_en && (r_cnt == c_last_bit)) w_state_nxt = ST_DONE;
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Output decode from state and register contents; only ser_valid sees an input
    always_comb begin
        load_ready = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        sel_out    = 1'b0;
        ser_valid  = 1'b0;
        ser_out    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                load_ready = 1'b1;
            end
            ST_SHIFT: begin
                busy      = 1'b1;
                sel_out   = 1'b1;
                ser_valid = shift_en;
                ser_out   = w_ser_bit;
            end
            ST_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                load_ready = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_piso_shift_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_piso_shift_ctrl
// Description : Scoreboard bench for piso_shift_ctrl. Two instances (LSB-first
//               and MSB-first) share the stimulus; a frame-level model queues
//               the expected serial bits and a negedge monitor compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_piso_shift_ctrl;

    localparam int W = 4;

    localparam int P_IDLE  = 0;
    localparam int P_SHIFT = 1;
    localparam int P_DONE  = 2;

    logic         clk        = 1'b0;
    logic         rst_n      = 1'b0;
    logic         load_valid = 1'b0;
    logic         shift_en   = 1'b0;
    logic [W-1:0] par_in     = '0;

    logic l_ready, l_ser, l_sval, l_sel, l_busy, l_done;
    logic m_ready, m_ser, m_sval, m_sel, m_busy, m_done;

    typedef struct packed {
        logic lsb;
        logic msb;
    } exp_t;

    exp_t q_exp[$];
    int   m_phase = P_IDLE;
    int   m_left  = 0;
    int   checks  = 0;
    int   errors  = 0;
    logic [5:0] exp_ctl;
    exp_t e_front;

    piso_shift_ctrl #(.WIDTH(W), .LSB_FIRST(1'b1), .FILL(1'b0)) u_lsb (
        .clk        (clk),
        .rst_n      (rst_n),
        .par_in     (par_in),
        .load_valid (load_valid),
        .load_ready (l_ready),
        .shift_en   (shift_en),
        .ser_out    (l_ser),
        .ser_valid  (l_sval),
        .sel_out    (l_sel),
        .busy       (l_busy),
        .done       (l_done)
    );

    piso_shift_ctrl #(.WIDTH(W), .LSB_FIRST(1'b0), .FILL(1'b0)) u_msb (
        .clk        (clk),
        .rst_n      (rst_n),
        .par_in     (par_in),
        .load_valid (load_valid),
        .load_ready (m_ready),
        .shift_en   (shift_en),
        .ser_out    (m_ser),
        .ser_valid  (m_sval),
        .sel_out    (m_sel),
        .busy       (m_busy),
        .done       (m_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level reference: a word becomes W queued bits, then one done cycle
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = P_IDLE;
            m_left  = 0;
            q_exp.delete();
        end else begin
            case (m_phase)
                P_IDLE: begin
                    if (load_valid) begin
                        for (int i = 0; i < W; i++) begin
                            q_exp.push_back('{lsb: par_in[i], msb: par_in[W-1-i]});
                        end
                        m_left  = W;
                        m_phase = P_SHIFT;
                    end
                end
                P_SHIFT: begin
                    if (shift_en) begin
                        m_left = m_left - 1;
                        if (m_left == 0) m_phase = P_DONE;
                    end
                end
                default: m_phase = P_IDLE;
            endcase
        end
    end

    // Monitor: compare handshake/status every cycle, pop a bit on each valid beat
    always @(negedge clk) begin
        exp_ctl = {1'b0, m_phase == P_IDLE, m_phase != P_IDLE, m_phase == P_DONE,
                   m_phase == P_SHIFT, (m_phase == P_SHIFT) && shift_en};
        check("ctl_lsb", {1'b0, l_ready, l_busy, l_done, l_sel, l_sval}, exp_ctl);
        check("ctl_msb", {1'b0, m_ready, m_busy, m_done, m_sel, m_sval}, exp_ctl);
        if (m_phase == P_SHIFT) begin
            if (q_exp.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard: no expected bit at %0t", $time);
            end else begin
                e_front = q_exp[0];
                check("ser_lsb", {5'b0, l_ser}, {5'b0, e_front.lsb});
                check("ser_msb", {5'b0, m_ser}, {5'b0, e_front.msb});
                if (shift_en) void'(q_exp.pop_front());
            end
        end else if (m_phase == P_DONE) begin
            check("frame_drained", {5'b0, q_exp.size() == 0}, 6'd1);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (m_phase != P_IDLE && n < 100) begin
            step();
            n++;
        end
        if (m_phase != P_IDLE) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: timeout after %0d cycles", n);
        end
    endtask

    task automatic check_reset_vals();
        check("rst_lsb", {l_ready, l_busy, l_done, l_sel, l_sval, l_ser}, 6'b100000);
        check("rst_msb", {m_ready, m_busy, m_done, m_sel, m_sval, m_ser}, 6'b100000);
    endtask

    task automatic load_word(input logic [W-1:0] d);
        load_valid = 1'b1;
        par_in     = d;
        step();
        load_valid = 1'b0;
    endtask

    initial begin
        // Power-on reset
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals();
        rst_n = 1'b1;
        step();

        // Unstalled frame, both serialisation orders
        shift_en = 1'b1;
        load_word(4'b1011);
        wait_idle();
        step();

        // Stall for two cycles after the first bit
        load_word(4'b0110);
        shift_en = 1'b1;
        step();
        shift_en = 1'b0;
        step();
        step();
        shift_en = 1'b1;
        wait_idle();
        step();

        // Back-pressure: second word held until IDLE
        load_valid = 1'b1;
        par_in     = 4'b0101;
        step();
        par_in     = 4'b1001;
        wait_idle();
        step();
        load_valid = 1'b0;
        wait_idle();
        step();

        // Abort after two bits, then a clean frame
        load_word(4'b1100);
        shift_en = 1'b1;
        step();
        step();
        rst_n = 1'b0;
        #1;
        check_reset_vals();
        step();
        rst_n = 1'b1;
        step();
        load_word(4'b0011);
        wait_idle();
        step();

        // Asynchronous reset during SHIFT with an all-ones register
        load_word(4'b1111);
        step();
        rst_n = 1'b0;
        #1;
        check_reset_vals();
        step();
        rst_n = 1'b1;
        step();

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            load_valid = 1'($urandom_range(0, 1));
            par_in     = W'($urandom);
            shift_en   = ($urandom_range(0, 3) != 0);
            step();
        end
        load_valid = 1'b0;
        shift_en   = 1'b1;
        wait_idle();
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
